floo_req_link_arbiter: RTL

Shares the single FlooReq physical link between the three request-class AXI channels of a single-AXI network interface (AW, W, AR). Each cycle it picks one eligible channel and forwards that channel's flit onto the link. Selection is round-robin, with two rules on top:
- W bursts are wormhole-locked: once a burst starts, nothing else is sent until its last beat.
- A W beat is sent only after its AW has been sent.
It sits in the chimney between the per-channel flit packers and the router-facing request output.

---
 rtl/floo_pkg.sv | 26 ++
 rtl/floo_rr_sel.sv | 28 ++
 rtl/floo_req_link_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/floo_pkg.sv
// Shared FlooNoC definitions: AXI channel enumeration and request-link slot mapping.
package floo_pkg;

   typedef enum logic [2:0] {
      AxiAw = 3'd0,
      AxiW  = 3'd1,
      AxiAr = 3'd2,
      AxiB  = 3'd3,
      AxiR  = 3'd4
   } axi_ch_e;

   localparam int unsigned NumReqChannels = 3;

   // Slot of an AXI channel on the shared request link (response channels never use it).
   function automatic logic [1:0] axi_chan_mapping(input axi_ch_e ch);
      logic [1:0] idx;
      case (ch)
         AxiAw:   idx = 2'd0;
         AxiW:    idx = 2'd1;
         AxiAr:   idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/floo_rr_sel.sv
// Combinational 3-way round-robin priority selector: first eligible slot starting at rr_i.
module floo_rr_sel
   import floo_pkg::*;
(
   input  logic [NumReqChannels-1:0] eligible_i,
   input  logic [1:0]                rr_i,
   output logic [NumReqChannels-1:0] grant_oh_o,
   output logic [1:0]                grant_idx_o,
   output logic                      any_o
);

   // Scan from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      logic [2:0] pos;
      grant_oh_o  = '0;
      grant_idx_o = 2'd0;
      any_o       = |eligible_i;
      for (int k = NumReqChannels - 1; k >= 0; k--) begin
         pos = {1'b0, rr_i} + 3'(k);
         if (pos >= 3'(NumReqChannels)) pos = pos - 3'(NumReqChannels);
         if (eligible_i[pos[1:0]]) begin
            grant_idx_o = pos[1:0];
            grant_oh_o  = 3'b001 << pos[1:0];
         end
      end
   end

endmodule

// File: rtl/floo_req_link_arbiter.sv
// Shares the FlooReq link between AW, W and AR: round-robin, W-burst wormhole lock,
// W held back until its AW has gone out, and stall hold while the link is not ready.
module floo_req_link_arbiter
   import floo_pkg::*;
#(
   parameter int unsigned FlitWidth        = 64,
   parameter int unsigned MaxOutstandingAw = 4
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NumReqChannels-1:0]               valid_i,
   output logic [NumReqChannels-1:0]               ready_o,
   input  logic [NumReqChannels*FlitWidth-1:0]     data_i,
   input  logic                                    w_last_i,
   output logic                                    valid_o,
   input  logic                                    ready_i,
   output logic [FlitWidth-1:0]                    data_o,
   output logic [$clog2(MaxOutstandingAw+1)-1:0]   aw_pending_o,
   output logic                                    locked_o
);

   localparam int unsigned CntW = $clog2(MaxOutstandingAw + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstandingAw);
   localparam logic [1:0] IdxAw = axi_chan_mapping(AxiAw);
   localparam logic [1:0] IdxW  = axi_chan_mapping(AxiW);
   localparam logic [1:0] IdxAr = axi_chan_mapping(AxiAr);

   logic [1:0]      rr_q, rr_d;
   logic            lock_q, lock_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            hold_q, hold_d;
   logic [1:0]      hold_idx_q, hold_idx_d;

   logic [NumReqChannels-1:0] eligible, sel_oh, grant_oh;
   logic [1:0]                sel_idx, grant;
   logic                      sel_any, hs, gnt_aw, gnt_w;

   always_comb begin
      eligible        = '0;
      eligible[IdxAw] = valid_i[IdxAw] && (cnt_q < MaxCnt) && !lock_q;
      eligible[IdxW]  = valid_i[IdxW] && (cnt_q != '0);
      eligible[IdxAr] = valid_i[IdxAr] && !lock_q;
   end

   floo_rr_sel i_rr_sel (
      .eligible_i  (eligible),
      .rr_i        (rr_q),
      .grant_oh_o  (sel_oh),
      .grant_idx_o (sel_idx),
      .any_o       (sel_any)
   );

   // A held grant bypasses eligibility so the presented flit cannot change mid-stall.
   always_comb begin
      grant    = hold_q ? hold_idx_q : sel_idx;
      grant_oh = hold_q ? (3'b001 << hold_idx_q) : sel_oh;
      valid_o  = !rst_i && (hold_q || sel_any);
      hs       = valid_o && ready_i;
      ready_o  = hs ? grant_oh : '0;
      gnt_aw   = hs && (grant == IdxAw);
      gnt_w    = hs && (grant == IdxW);
      case (grant)
         2'd0:    data_o = data_i[0*FlitWidth +: FlitWidth];
         2'd1:    data_o = data_i[1*FlitWidth +: FlitWidth];
         2'd2:    data_o = data_i[2*FlitWidth +: FlitWidth];
         default: data_o = '0;
      endcase
   end

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      hold_idx_d = hold_idx_q;
      if (hs && !lock_q) rr_d = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
      if (gnt_w) lock_d = !w_last_i;
      if (gnt_aw) cnt_d = cnt_q + CntW'(1);
      else if (gnt_w && w_last_i) cnt_d = cnt_q - CntW'(1);
      if (valid_o && !ready_i) begin
         hold_d     = 1'b1;
         hold_idx_d = grant;
      end else if (hs) begin
         hold_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= 2'd0;
         lock_q     <= 1'b0;
         cnt_q      <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= 2'd0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
      end
   end

   assign aw_pending_o = cnt_q;
   assign locked_o     = lock_q;

endmodule
